mydiv_seq: RTL and testbench

//   Sequential signed fixed-point divider, c = a / b. Inverse of the fixed-point multiplier.

---
 rtl/mydiv_seq_if.sv | 26 ++
 rtl/mydiv_seq.sv | 159 +++++++++++++++
 tb/tb_mydiv_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mydiv_seq_if.sv
// rtl/mydiv_seq_if.sv - operand/result handshake bundle for the sequential divider
interface mydiv_seq_if #(
    parameter int a_bits = 16,
    parameter int b_bits = 16,
    parameter int c_bits = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [a_bits-1:0] a;
    logic signed [b_bits-1:0] b;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [c_bits-1:0] c;
    logic                     div_zero;
    logic                     ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, div_zero, ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, div_zero, ovf
    );
endinterface

// File: rtl/mydiv_seq.sv
// rtl/mydiv_seq.sv - signed fixed-point restoring divider, one quotient bit per clock
module mydiv_seq #(
    parameter int a_bits  = 16,
    parameter int a_point = 8,
    parameter int b_bits  = 16,
    parameter int b_point = 8,
    parameter int c_bits  = 16,
    parameter int c_point = 8
) (
    input  logic         clk,
    input  logic         rst,
    mydiv_seq_if.slave   bus
);
    localparam int SHIFT = c_point - a_point + b_point;
    localparam int SHL   = (SHIFT > 0) ? SHIFT : 0;
    localparam int SHR   = (SHIFT < 0) ? -SHIFT : 0;
    localparam int NW    = a_bits + SHL;
    localparam int RW    = b_bits + 1;
    localparam int CW    = $clog2(NW + 1);
    localparam int EW    = NW + c_bits + 1;

    localparam logic [EW-1:0]     NEG_LIM = EW'(1) << (c_bits - 1);
    localparam logic [EW-1:0]     POS_LIM = NEG_LIM - EW'(1);
    localparam logic [c_bits-1:0] C_MAX   = {1'b0, {(c_bits-1){1'b1}}};
    localparam logic [c_bits-1:0] C_MIN   = {1'b1, {(c_bits-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;

    logic [NW-1:0]     num;
    logic [NW-1:0]     quo;
    logic [b_bits-1:0] rem;
    logic [b_bits-1:0] babs;
    logic              sign;
    logic              dz;
    logic              neg_a;
    logic [CW-1:0]     cnt;

    logic [c_bits-1:0] c_r;
    logic              dz_r;
    logic              ovf_r;

    logic [a_bits-1:0] aabs_w;
    logic [b_bits-1:0] babs_w;
    logic [NW-1:0]     num_w;
    logic [RW-1:0]     rem_sh;
    logic [RW-1:0]     rem_sub;
    logic              ge;
    logic [EW-1:0]     qext;
    logic [c_bits-1:0] sat_c;
    logic              sat_ovf;
    logic              calc_end;

    // Magnitudes are taken as unsigned so the most negative operand maps without wrapping
    always_comb begin
        aabs_w = bus.a[a_bits-1] ? $unsigned(-bus.a) : $unsigned(bus.a);
        babs_w = bus.b[b_bits-1] ? $unsigned(-bus.b) : $unsigned(bus.b);
        num_w  = (NW'(aabs_w) << SHL) >> SHR;
    end

    always_comb begin
        rem_sh  = {rem, num[NW-1]};
        ge      = (rem_sh >= {1'b0, babs});
        rem_sub = rem_sh - {1'b0, babs};
    end

    always_comb begin
        qext    = EW'(quo);
        sat_c   = '0;
        sat_ovf = 1'b0;
        if (sign) begin
            if (qext > NEG_LIM) begin
                sat_c   = C_MIN;
                sat_ovf = 1'b1;
            end else begin
                sat_c   = c_bits'(EW'(0) - qext);
            end
        end else begin
            if (qext > POS_LIM) begin
                sat_c   = C_MAX;
                sat_ovf = 1'b1;
            end else begin
                sat_c   = c_bits'(qext);
            end
        end
    end

    assign calc_end = dz || (cnt == CW'(NW));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = CALC;
            CALC:    if (calc_end)     state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One extra CALC cycle after the last iteration registers the saturated result
    always_ff @(posedge clk) begin
        if (rst) begin
            num   <= '0;
            quo   <= '0;
            rem   <= '0;
            babs  <= '0;
            sign  <= 1'b0;
            dz    <= 1'b0;
            neg_a <= 1'b0;
            cnt   <= '0;
            c_r   <= '0;
            dz_r  <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        num   <= num_w;
                        babs  <= babs_w;
                        sign  <= bus.a[a_bits-1] ^ bus.b[b_bits-1];
                        dz    <= (bus.b == '0);
                        neg_a <= bus.a[a_bits-1];
                        rem   <= '0;
                        quo   <= '0;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    if (dz) begin
                        c_r   <= neg_a ? C_MIN : C_MAX;
                        dz_r  <= 1'b1;
                        ovf_r <= 1'b0;
                    end else if (calc_end) begin
                        c_r   <= sat_c;
                        dz_r  <= 1'b0;
                        ovf_r <= sat_ovf;
                    end else begin
                        num <= num << 1;
                        rem <= ge ? b_bits'(rem_sub) : b_bits'(rem_sh);
                        quo <= {quo[NW-2:0], ge};
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.c         = c_r;
    assign bus.div_zero  = dz_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_mydiv_seq.sv
// tb/tb_mydiv_seq.sv - self-checking bench for mydiv_seq at the default 16/8 formats
module tb_mydiv_seq;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    bit   chk_on = 1'b0;

    always #5 clk = ~clk;

    mydiv_seq_if bus ();

    mydiv_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // c = a*2^8 / b, truncated toward zero, then clamped to 16-bit signed
    function automatic void model(input int ia, input int ib, output int ec, output bit eo, output bit ed);
        longint q;
        if (ib == 0) begin
            ed = 1'b1;
            eo = 1'b0;
            ec = (ia >= 0) ? 32767 : -32768;
        end else begin
            ed = 1'b0;
            q  = (longint'(ia) * 256) / longint'(ib);
            if (q > 32767) begin
                ec = 32767;  eo = 1'b1;
            end else if (q < -32768) begin
                ec = -32768; eo = 1'b1;
            end else begin
                ec = int'(q); eo = 1'b0;
            end
        end
    endfunction

    int ncyc = 0;
    int acc_n, lat, m_c;
    bit m_o, m_d, busy = 1'b0, pending = 1'b0, seen;

    always @(negedge clk) begin
        if (chk_on) begin
            ncyc++;
            check("in_ready", bus.in_ready, !busy);
            if (bus.out_valid) begin
                if (!pending) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    if (!seen) check("latency", ncyc - acc_n, lat);
                    seen = 1'b1;
                    check("c", longint'(bus.c), m_c);
                    check("ovf", bus.ovf, m_o);
                    check("div_zero", bus.div_zero, m_d);
                end
            end else if (pending && !seen && (ncyc - acc_n) >= lat) begin
                check("late_out_valid", 0, 1);
                pending = 1'b0;
            end
            if (rst) begin
                busy    = 1'b0;
                pending = 1'b0;
            end else if (bus.in_valid && bus.in_ready) begin
                busy    = 1'b1;
                pending = 1'b1;
                seen    = 1'b0;
                acc_n   = ncyc;
                model(int'(bus.a), int'(bus.b), m_c, m_o, m_d);
                lat     = (bus.b == 0) ? 2 : 26;
            end else if (bus.out_valid && bus.out_ready) begin
                busy    = 1'b0;
                pending = 1'b0;
            end
        end
    end

    task automatic do_div(input logic signed [15:0] ta, input logic signed [15:0] tb_v,
                          input int ec, input bit eo, input bit ed, input bit lit, input int hold);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            if (bus.in_ready) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!got) begin
            check("wait_in_ready", 0, 1);
            return;
        end
        bus.in_valid = 1'b1;
        bus.a        = ta;
        bus.b        = tb_v;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            if (bus.out_valid) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!got) begin
            check("wait_out_valid", 0, 1);
            return;
        end
        if (lit) begin
            check("lit_c", longint'(bus.c), ec);
            check("lit_ovf", bus.ovf, eo);
            check("lit_div_zero", bus.div_zero, ed);
        end
        for (int k = 0; k < hold; k++) begin
            check("hold_in_ready", bus.in_ready, 0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("post_ack_in_ready", bus.in_ready, 1);
        check("post_ack_out_valid", bus.out_valid, 0);
    endtask

    localparam int NV = 20;
    int vec_a  [NV] = '{768, -768, -768, 25600, -25600, 5, -5, 0, -32768, -32768,
                        32767, -128, 1, -1, 100, -32768, 32767, 0, 3, -3};
    int vec_b  [NV] = '{512, 512, -512, 1, 1, 0, 0, 7, -32768, 256,
                        256, -32768, 3, 3, -7, 255, 255, 0, -1, -1};
    int vec_c  [NV] = '{384, -384, 384, 32767, -32768, 32767, -32768, 0, 256, -32768,
                        32767, 1, 85, -85, -3657, -32768, 32767, 32767, -768, 768};
    bit vec_o  [NV] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0,
                        0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    bit vec_d  [NV] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0,
                        0, 0, 0, 0, 0, 0, 0, 1, 0, 0};

    initial begin
        int pc;
        bit po, pd;
        logic signed [15:0] ra, rb;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;

        model(768, 512, pc, po, pd);     check("model_768_512", pc, 384);
        model(-768, -512, pc, po, pd);   check("model_neg_neg", pc, 384);
        model(-25600, 1, pc, po, pd);    check("model_sat_neg_ovf", po, 1);
        model(-5, 0, pc, po, pd);        check("model_dz_neg", pc, -32768);

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_c", longint'(bus.c), 0);
        check("rst_div_zero", bus.div_zero, 0);
        check("rst_ovf", bus.ovf, 0);
        rst    = 1'b0;
        chk_on = 1'b1;

        for (int i = 0; i < NV; i++)
            do_div(16'(vec_a[i]), 16'(vec_b[i]), vec_c[i], vec_o[i], vec_d[i], 1'b1, i % 3);

        do_div(16'sd768, 16'sd512, 384, 1'b0, 1'b0, 1'b1, 5);

        bus.in_valid = 1'b1;
        bus.a        = 16'sd1000;
        bus.b        = 16'sd300;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_c", longint'(bus.c), 0);
        repeat (40) @(posedge clk);
        #1;
        do_div(16'sd768, 16'sd512, 384, 1'b0, 1'b0, 1'b1, 0);

        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom);
            rb = (i % 4 == 0) ? 16'($signed($urandom_range(0, 16)) - 8) : 16'($urandom);
            do_div(ra, rb, 0, 1'b0, 1'b0, 1'b0, i % 2);
        end

        repeat (5) @(posedge clk);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
